// File: rtl/fetch_unit.sv
// Instruction-fetch unit: owns the PC, issues N = IW/MW narrow reads and assembles
// them into one instruction word. Define FETCH_BIG_ENDIAN_EN to place lane 0 in the MSBs.
module fetch_unit #(
    parameter int            MW       = 8,
    parameter int            IW       = 32,
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_req,
    input  logic          pcen,
    input  logic [AW-1:0] pc_next,
    input  logic [MW-1:0] memdata,
    input  logic          mem_valid,
    output logic          mem_req,
    output logic [AW-1:0] adr,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ack,
    output logic [AW-1:0] pc,
    output logic          busy
);

    localparam int            N         = IW / MW;
    localparam int            LW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(N - 1);
    localparam logic [AW-1:0] PC_STEP   = AW'(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          instr_valid_q, instr_valid_d;

    // Drop one memory beat into its lane slot; other lanes keep their old contents.
    function automatic logic [IW-1:0] lane_write(
        input logic [IW-1:0] word,
        input logic [LW-1:0] lane,
        input logic [MW-1:0] data
    );
        logic [IW-1:0] res;
        res = word;
        for (int k = 0; k < N; k++) begin
            if (lane == LW'(k)) begin
`ifdef FETCH_BIG_ENDIAN_EN
                res[(N-1-k)*MW +: MW] = data;
`else
                res[k*MW +: MW] = data;
`endif
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, PC, lane and instruction assembly.
    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (pcen) begin
                    pc_d = pc_next;
                end else begin
                    pc_d = pc_q;
                end
                if (fetch_req) begin
                    state_d = ST_FETCH;
                    lane_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FETCH: begin
                // A branch wins over any same-cycle capture, including the last lane.
                if (pcen) begin
                    pc_d          = pc_next;
                    lane_d        = '0;
                    instr_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end else if (mem_valid) begin
                    instr_d = lane_write(instr_q, lane_q, memdata);
                    if (lane_q == LANE_LAST) begin
                        pc_d          = pc_q + PC_STEP;
                        lane_d        = '0;
                        instr_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_HOLD: begin
                if (pcen || instr_ack) begin
                    instr_valid_d = 1'b0;
                    if (pcen) begin
                        pc_d = pc_next;
                    end else begin
                        pc_d = pc_q;
                    end
                    if (fetch_req) begin
                        state_d = ST_FETCH;
                        lane_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d       = ST_IDLE;
                lane_d        = '0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State, PC and instruction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lane_q        <= '0;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign mem_req     = (state_q == ST_FETCH);
    assign busy        = (state_q == ST_FETCH);
    assign adr         = pc_q + AW'(lane_q);
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch unit for the multicycle datapath. It replaces hand-driven per-byte IR write enables with an internal lane sequencer. The unit owns the PC, issues consecutive narrow memory reads, and assembles them into one wide instruction word. It then presents that word to the control FSM through a valid/ack handshake. It sits between the memory port and the instruction register / control unit.

## Interface
Parameters:
- MW, 8: memory data width (bits per read)
- IW, 32: instruction width; must be an integer multiple of MW; N = IW/MW lanes
- AW, 8: address / PC width
- RESET_PC, 0: PC value after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_req  in  1  control requests the next instruction
- pcen  in  1  load PC from pc_next (branch/jump); flushes any fetch in progress
- pc_next  in  AW  new PC value for pcen
- memdata  in  MW  memory read data
- mem_valid  in  1  memdata valid this cycle for current adr
- mem_req  out  1  read request; high only in FETCH
- adr  out  AW  read address = pc + lane (mod 2^AW)
- instr  out  IW  assembled instruction
- instr_valid  out  1  instr complete and held
- instr_ack  in  1  control has consumed instr
- pc  out  AW  current PC
- busy  out  1  high in FETCH

## Operation
- FSM states: IDLE, FETCH, HOLD. The lane counter runs 0..N-1 and is ceil(log2 N) bits wide, with a minimum of 1.
- IDLE:
  - fetch_req goes to FETCH with lane=0.
  - pcen loads pc_next.
  - If pcen and fetch_req are both high, load pc_next and go to FETCH. The fetch uses the new PC.
- FETCH:
  - mem_req=1 and adr=pc+lane.
  - When mem_valid is high, memdata is written into lane `lane` of instr, and lane increments.
  - When mem_valid is low, everything holds (wait state).
  - On capture of lane N-1: pc <= pc+N (mod 2^AW), instr_valid <= 1, next state HOLD.
  - pcen in FETCH aborts the fetch:
    - pc <= pc_next, lane <= 0, next state IDLE.
    - instr_valid stays 0. Partially written lanes are don't-care.
    - pcen beats a same-cycle last-lane capture; pc is not incremented.
- HOLD:
  - instr is stable and instr_valid=1.
  - instr_ack alone: instr_valid <= 0, next state IDLE.
  - instr_ack and fetch_req together: next state FETCH (back-to-back), instr_valid <= 0.
  - pcen in HOLD loads pc_next, clears instr_valid and goes to IDLE. This applies regardless of instr_ack. fetch_req behaves as in IDLE.
- fetch_req is ignored in FETCH.
- instr_ack is ignored outside HOLD.
- Lane mapping (default, little-endian): lane k -> instr[k*MW +: MW].
- Lanes not yet written in the current fetch keep their previous values until they are overwritten.

## Timing
- Reset values (asynchronous): state=IDLE, lane=0, pc=RESET_PC, instr=0, instr_valid=0, busy=0, mem_req=0, adr=RESET_PC.
- mem_req, adr and busy are decoded combinationally from registered state, pc and lane. They do not depend on mem_valid.
- Latency: fetch_req is sampled at edge E0. With mem_valid held high, lane k is captured at edge E(k+1), and instr_valid rises after edge EN. Each mem_valid-low cycle adds one cycle.
- Back-to-back throughput: N+1 cycles per instruction when ack and req arrive together in HOLD.
- Reset asserted mid-fetch returns to reset values immediately, without waiting for a clock edge.

## Configuration
- FETCH_BIG_ENDIAN_EN:
  - When defined, lane k maps to instr[(N-1-k)*MW +: MW], so the first byte fetched lands in the MSBs.
  - When undefined, the little-endian mapping above applies.
  - Addressing, PC increment and handshake are identical in both builds.

## Test plan
- Basic fetch. Setup: default parameters, pc=0, fetch_req pulse; memdata 0x20, 0x20, 0x85, 0x00 with mem_valid high. Required: adr 0,1,2,3; instr=0x00852020; instr_valid high after 4th edge; pc=4. With FETCH_BIG_ENDIAN_EN: instr=0x20208500.
- Wait states. Stimulus: same bytes, with mem_valid low for 2 cycles before lane 2. Required: adr holds at 2 and lane does not advance; instr_valid arrives 2 cycles later; same instr value.
- Branch flush. Stimulus: pcen with pc_next=0x40 asserted during lane 1. Required: next state IDLE, pc=0x40, instr_valid stays 0. A following fetch reads adr 0x40..0x43, and pc ends at 0x44.
- Simultaneous events. Stimulus: pcen with pc_next=0x10 in the same cycle as the last-lane capture. Required: pc=0x10 (not incremented), instr_valid=0. Separately, ack+req together in HOLD: instr_valid drops and FETCH restarts at the new pc with no IDLE cycle.
- Wrap-around. Stimulus: pcen with pc_next=0xFE, then fetch. Required: adr 0xFE, 0xFF, 0x00, 0x01; pc=0x02.
- Reset mid-fetch. Stimulus: assert reset between edges during lane 2. Required: mem_req=0, pc=0, instr=0, instr_valid=0 immediately, before the next edge.
